// File: rtl/euler_step_seq_pkg.sv
// Shared opcode and state definitions for the Euler step sequencer and its ALU.
// DAMPING_EN adds the S_DAMP state between the velocity update and the position multiply.
package euler_step_seq_pkg;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_MUL = 2'b10,
      ALU_DIV = 2'b11
   } alu_op_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MUL_AV,
      S_ADD_V,
`ifdef DAMPING_EN
      S_DAMP,
`endif
      S_MUL_PV,
      S_ADD_P,
      S_DONE
   } state_e;

endpackage

// File: rtl/euler_step_seq_alu.sv
// Combinational signed fixed-point ALU (N/2 fraction bits) sitting beside euler_step_seq.
// Results wrap modulo 2^N; division by zero returns zero.
module euler_step_seq_alu
   import euler_step_seq_pkg::*;
#(
   parameter int N = 32
) (
   input  logic [N-1:0] alu_a,
   input  logic [N-1:0] alu_b,
   input  logic [1:0]   alu_op,
   output logic [N-1:0] alu_result
);

   logic signed [2*N-1:0] a_ext;
   logic signed [2*N-1:0] b_ext;
   logic signed [2*N-1:0] num;

   assign a_ext = $signed({{N{alu_a[N-1]}}, alu_a});
   assign b_ext = $signed({{N{alu_b[N-1]}}, alu_b});
   // Dividend pre-scaled by 2^(N/2) so the quotient keeps the fixed-point format.
   assign num   = $signed({{(N/2){alu_a[N-1]}}, alu_a, {(N/2){1'b0}}});

   always_comb begin
      alu_result = '0;
      case (alu_op_e'(alu_op))
         ALU_ADD: alu_result = alu_a + alu_b;
         ALU_SUB: alu_result = alu_a - alu_b;
         ALU_MUL: alu_result = N'((a_ext * b_ext) >>> (N/2));
         ALU_DIV: alu_result = (alu_b == '0) ? '0 : N'(num / b_ext);
         default: alu_result = '0;
      endcase
   end

endmodule

// File: rtl/euler_step_seq.sv
// Semi-implicit Euler step (v' = v + a*dt, p' = p + v'*dt) sequenced through an external ALU.
// Define DAMPING_EN to add damp_in and an S_DAMP step (v' *= damp) before the position update.
module euler_step_seq
   import euler_step_seq_pkg::*;
#(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] pos_in,
   input  logic [N-1:0] vel_in,
   input  logic [N-1:0] acc_in,
   input  logic [N-1:0] dt_in,
`ifdef DAMPING_EN
   input  logic [N-1:0] damp_in,
`endif
   output logic [N-1:0] alu_a,
   output logic [N-1:0] alu_b,
   output logic [1:0]   alu_op,
   input  logic [N-1:0] alu_result,
   output logic [N-1:0] pos_out,
   output logic [N-1:0] vel_out,
   output logic         busy,
   output logic         done
);

   state_e        state_q, state_d;
   alu_op_e       op_sel;
   logic [N-1:0]  pos_q, pos_d, vel_q, vel_d, acc_q, acc_d, dt_q, dt_d;
   logic [N-1:0]  tmp_q, tmp_d, pos_r_q, pos_r_d, vel_r_q, vel_r_d;
   logic [N-1:0]  pos_out_q, pos_out_d, vel_out_q, vel_out_d;
   logic          busy_q, busy_d, done_q, done_d;
`ifdef DAMPING_EN
   logic [N-1:0]  damp_q, damp_d;
`endif

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      pos_d     = pos_q;
      vel_d     = vel_q;
      acc_d     = acc_q;
      dt_d      = dt_q;
`ifdef DAMPING_EN
      damp_d    = damp_q;
`endif
      tmp_d     = tmp_q;
      pos_r_d   = pos_r_q;
      vel_r_d   = vel_r_q;
      pos_out_d = pos_out_q;
      vel_out_d = vel_out_q;
      alu_a     = '0;
      alu_b     = '0;
      op_sel    = ALU_ADD;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               pos_d   = pos_in;
               vel_d   = vel_in;
               acc_d   = acc_in;
               dt_d    = dt_in;
`ifdef DAMPING_EN
               damp_d  = damp_in;
`endif
               state_d = S_MUL_AV;
            end
         end
         S_MUL_AV: begin
            alu_a   = acc_q;
            alu_b   = dt_q;
            op_sel  = ALU_MUL;
            tmp_d   = alu_result;
            state_d = S_ADD_V;
         end
         S_ADD_V: begin
            alu_a   = vel_q;
            alu_b   = tmp_q;
            op_sel  = ALU_ADD;
            vel_r_d = alu_result;
`ifdef DAMPING_EN
            state_d = S_DAMP;
`else
            state_d = S_MUL_PV;
`endif
         end
`ifdef DAMPING_EN
         S_DAMP: begin
            alu_a   = vel_r_q;
            alu_b   = damp_q;
            op_sel  = ALU_MUL;
            vel_r_d = alu_result;
            state_d = S_MUL_PV;
         end
`endif
         S_MUL_PV: begin
            alu_a   = vel_r_q;
            alu_b   = dt_q;
            op_sel  = ALU_MUL;
            tmp_d   = alu_result;
            state_d = S_ADD_P;
         end
         S_ADD_P: begin
            alu_a     = pos_q;
            alu_b     = tmp_q;
            op_sel    = ALU_ADD;
            pos_r_d   = alu_result;
            // Outputs load together with pos_r so they are valid in the done cycle.
            pos_out_d = alu_result;
            vel_out_d = vel_r_q;
            state_d   = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      busy_d = !(state_d inside {S_IDLE, S_DONE});
      done_d = (state_d == S_DONE);
   end

   assign alu_op  = op_sel;
   assign pos_out = pos_out_q;
   assign vel_out = vel_out_q;
   assign busy    = busy_q;
   assign done    = done_q;

   // NOTE: reset is synchronous and wins over every other update, including start.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         pos_q     <= '0;
         vel_q     <= '0;
         acc_q     <= '0;
         dt_q      <= '0;
`ifdef DAMPING_EN
         damp_q    <= '0;
`endif
         tmp_q     <= '0;
         pos_r_q   <= '0;
         vel_r_q   <= '0;
         pos_out_q <= '0;
         vel_out_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pos_q     <= pos_d;
         vel_q     <= vel_d;
         acc_q     <= acc_d;
         dt_q      <= dt_d;
`ifdef DAMPING_EN
         damp_q    <= damp_d;
`endif
         tmp_q     <= tmp_d;
         pos_r_q   <= pos_r_d;
         vel_r_q   <= vel_r_d;
         pos_out_q <= pos_out_d;
         vel_out_q <= vel_out_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

endmodule

// File: tb/tb_euler_step_seq.sv
// Self-checking bench for euler_step_seq wired to euler_step_seq_alu (N=32).
// Table-driven step vectors plus hand-written back-to-back and mid-step reset sequences.
module tb_euler_step_seq;
   import euler_step_seq_pkg::*;

   localparam int N = 32;
`ifdef DAMPING_EN
   localparam int LAT = 6;
`else
   localparam int LAT = 5;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [N-1:0]  pos_in = '0, vel_in = '0, acc_in = '0, dt_in = '0;
`ifdef DAMPING_EN
   logic [N-1:0]  damp_in = '0;
`endif
   logic [N-1:0]  alu_a, alu_b, alu_result, pos_out, vel_out;
   logic [1:0]    alu_op;
   logic          busy, done;

   int pass_cnt = 0;
   int total_cnt = 0;

   typedef struct {
      logic [N-1:0] pos, vel, acc, dt, damp;
      logic [N-1:0] exp_vel, exp_pos;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   euler_step_seq #(.N(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .pos_in     (pos_in),
      .vel_in     (vel_in),
      .acc_in     (acc_in),
      .dt_in      (dt_in),
`ifdef DAMPING_EN
      .damp_in    (damp_in),
`endif
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_op     (alu_op),
      .alu_result (alu_result),
      .pos_out    (pos_out),
      .vel_out    (vel_out),
      .busy       (busy),
      .done       (done)
   );

   euler_step_seq_alu #(.N(N)) u_alu (
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_op     (alu_op),
      .alu_result (alu_result)
   );

   task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
   endtask

   task automatic drive_ops(input vec_t v);
      pos_in = v.pos;
      vel_in = v.vel;
      acc_in = v.acc;
      dt_in  = v.dt;
`ifdef DAMPING_EN
      damp_in = v.damp;
`endif
   endtask

   task automatic scramble_ops();
      pos_in = ~pos_in;
      vel_in = ~vel_in;
      acc_in = ~acc_in;
      dt_in  = ~dt_in;
`ifdef DAMPING_EN
      damp_in = ~damp_in;
`endif
   endtask

   // One full step: accept, scramble inputs, wait for done (bounded), check results.
   task automatic run_step(input vec_t v, input int idx);
      int cyc;
      @(negedge clk);
      drive_ops(v);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      scramble_ops();
      cyc = 1;
      check($sformatf("v%0d busy_c1", idx), N'(busy), N'(1));
      check($sformatf("v%0d op_c1", idx), N'(alu_op), N'(ALU_MUL));
      check($sformatf("v%0d alu_a_c1", idx), alu_a, v.acc);
      check($sformatf("v%0d alu_b_c1", idx), alu_b, v.dt);
      while (!done && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check($sformatf("v%0d latency", idx), N'(cyc), N'(LAT));
      check($sformatf("v%0d vel_out", idx), vel_out, v.exp_vel);
      check($sformatf("v%0d pos_out", idx), pos_out, v.exp_pos);
      check($sformatf("v%0d busy_done", idx), N'(busy), N'(0));
      check($sformatf("v%0d alu_a_done", idx), alu_a, N'(0));
      @(negedge clk);
      check($sformatf("v%0d done_pulse", idx), N'(done), N'(0));
      check($sformatf("v%0d pos_hold", idx), pos_out, v.exp_pos);
   endtask

   initial begin
      int dones;
      int done_at[$];
      int busy_err;
      logic exp_busy;

      vecs.push_back('{pos: 32'h0001_0000, vel: 32'h0002_0000, acc: 32'h0000_8000, dt: 32'h0000_8000,
                       damp: 32'h0001_0000, exp_vel: 32'h0002_4000, exp_pos: 32'h0002_2000});
      vecs.push_back('{pos: 32'h0000_0000, vel: 32'h0000_0000, acc: 32'hFFFF_0000, dt: 32'h0001_0000,
                       damp: 32'h0001_0000, exp_vel: 32'hFFFF_0000, exp_pos: 32'hFFFF_0000});
      vecs.push_back('{pos: 32'h0003_0000, vel: 32'hFFFF_0000, acc: 32'h0002_0000, dt: 32'h0000_4000,
                       damp: 32'h0001_0000, exp_vel: 32'hFFFF_8000, exp_pos: 32'h0002_E000});
      vecs.push_back('{pos: 32'h7FFF_0000, vel: 32'h0001_0000, acc: 32'h0000_0000, dt: 32'h0001_0000,
                       damp: 32'h0001_0000, exp_vel: 32'h0001_0000, exp_pos: 32'h8000_0000});
      vecs.push_back('{pos: 32'h1234_5678, vel: 32'h00AB_CDEF, acc: 32'h0004_0000, dt: 32'h0000_0000,
                       damp: 32'h0001_0000, exp_vel: 32'h00AB_CDEF, exp_pos: 32'h1234_5678});
`ifdef DAMPING_EN
      vecs.push_back('{pos: 32'h0001_0000, vel: 32'h0002_0000, acc: 32'h0000_8000, dt: 32'h0000_8000,
                       damp: 32'h0000_8000, exp_vel: 32'h0001_2000, exp_pos: 32'h0001_9000});
`endif

      // Reset state
      repeat (2) @(negedge clk);
      check("rst pos_out", pos_out, '0);
      check("rst vel_out", vel_out, '0);
      check("rst busy", N'(busy), N'(0));
      check("rst done", N'(done), N'(0));
      check("rst alu_b", alu_b, '0);
      rst = 1'b0;

      foreach (vecs[i]) run_step(vecs[i], i);

      // start held high: done every LAT+1 cycles, busy low only in idle/done cycles
      @(negedge clk);
      drive_ops(vecs[0]);
      start = 1'b1;
      busy_err = 0;
      for (int k = 1; k <= 3 * (LAT + 1); k++) begin
         @(negedge clk);
         if (done) done_at.push_back(k);
         exp_busy = !((k % (LAT + 1)) == LAT || (k % (LAT + 1)) == 0);
         if (busy !== exp_busy) busy_err++;
      end
      start = 1'b0;
      check("b2b done count", N'(done_at.size()), N'(3));
      if (done_at.size() == 3) begin
         check("b2b done1", N'(done_at[0]), N'(LAT));
         check("b2b done2", N'(done_at[1]), N'(2 * LAT + 1));
         check("b2b done3", N'(done_at[2]), N'(3 * LAT + 2));
      end
      check("b2b busy pattern", N'(busy_err), N'(0));
      check("b2b vel_out", vel_out, vecs[0].exp_vel);

      // Reset during cycle 3 of a step aborts it and clears the outputs
      @(negedge clk);
      drive_ops(vecs[2]);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort pos_out", pos_out, '0);
      check("abort vel_out", vel_out, '0);
      check("abort busy", N'(busy), N'(0));
      dones = 0;
      repeat (10) begin
         @(negedge clk);
         if (done) dones++;
      end
      check("abort no done", N'(dones), N'(0));
      run_step(vecs[0], 100);

      // rst and start together: rst wins
      @(negedge clk);
      rst = 1'b1;
      start = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      start = 1'b0;
      check("rst_prio busy", N'(busy), N'(0));
      @(negedge clk);
      check("rst_prio idle", N'(busy), N'(0));
      check("rst_prio pos_out", pos_out, '0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
